roach_clk_rst_sequencer: RTL and testbench

Power-up and recovery sequencer for the board clock infrastructure: MMCMs, the IDELAYCTRL, and the design-wide reset. It holds the MMCM reset and then waits for stable lock. It then pulses the IDELAYCTRL reset, waits for IDELAYCTRL ready, and only then releases the system reset. It runs on the free-running EPB clock, so it stays alive while the MMCMs are unlocked. It retries on lock loss or timeout and latches a fault after a bounded number of retries.

---
 rtl/roach_clk_rst_sequencer.sv | 159 +++++++++++++++
 tb/tb_roach_clk_rst_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/roach_clk_rst_sequencer.sv
// Clock/reset power-up sequencer: MMCM reset -> stable lock -> IDELAYCTRL reset -> ready -> release sys_rst; retries, then latches FAULT.
// Latency: 2-FF input synchronisers + 1 decision cycle; all outputs registered from the next state, so they move with state.
// Backpressure: none; restart overrides everything. Optional AUX_LOCK_EN also requires the aux MMCM lock.
module roach_clk_rst_sequencer #(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int IDELAY_RST_CYCLES   = 16,
    parameter int RDY_TIMEOUT_CYCLES  = 4096,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       epb_clk,
    input  logic       epb_rst_n,
    input  logic       sys_clk_lock_in,
    input  logic       aux_clk_lock_in,
    input  logic       idelay_rdy,
    input  logic       restart,
    output logic       mmcm_reset,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                       max2(LOCK_TIMEOUT_CYCLES, IDELAY_RST_CYCLES)),
                                  RDY_TIMEOUT_CYCLES);
    localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    // Each state holds for exactly its parameter: load N-1, leave when the counter is 0.
    localparam logic [CNT_W-1:0] LD_RST_HOLD = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LOCK_TO  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_IDLY_RST = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RDY_TO   = CNT_W'(RDY_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_MMCM_RST    = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_LOCK_STABLE = 3'd2,
        S_IDLY_RST    = 3'd3,
        S_WAIT_RDY    = 3'd4,
        S_RUN         = 3'd5,
        S_FAULT       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_ld;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       sys_sync_q, rdy_sync_q;
    logic             mmcm_reset_q, idelay_rst_q, sys_rst_q, ready_q, fault_q;
    logic             lock_s, rdy_s, cnt_zero, fail, load;

    always_ff @(posedge epb_clk or negedge epb_rst_n) begin
        if (!epb_rst_n) begin
            sys_sync_q <= 2'b00;
            rdy_sync_q <= 2'b00;
        end else begin
            sys_sync_q <= {sys_sync_q[0], sys_clk_lock_in};
            rdy_sync_q <= {rdy_sync_q[0], idelay_rdy};
        end
    end

`ifdef AUX_LOCK_EN
    logic [1:0] aux_sync_q;

    always_ff @(posedge epb_clk or negedge epb_rst_n) begin
        if (!epb_rst_n) aux_sync_q <= 2'b00;
        else            aux_sync_q <= {aux_sync_q[0], aux_clk_lock_in};
    end

    assign lock_s = sys_sync_q[1] & aux_sync_q[1];
`else
    logic unused_aux_lock;
    assign unused_aux_lock = aux_clk_lock_in;
    assign lock_s          = sys_sync_q[1];
`endif

    assign rdy_s    = rdy_sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        cnt_ld  = '0;
        case (state_q)
            S_MMCM_RST:    if (cnt_zero) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK:   if (lock_s) state_d = S_LOCK_STABLE;
                           else if (cnt_zero) fail = 1'b1;
            S_LOCK_STABLE: if (!lock_s) state_d = S_WAIT_LOCK;
                           else if (cnt_zero) state_d = S_IDLY_RST;
            S_IDLY_RST:    if (cnt_zero) state_d = S_WAIT_RDY;
            // A lock drop outranks a simultaneous rdy: never start RUN on a dying clock.
            S_WAIT_RDY:    if (!lock_s) fail = 1'b1;
                           else if (rdy_s) state_d = S_RUN;
                           else if (cnt_zero) fail = 1'b1;
            S_RUN:         if (!lock_s) fail = 1'b1;
            S_FAULT:       state_d = S_FAULT;
            default:       state_d = S_MMCM_RST;
        endcase
        if (fail) begin
            retry_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_MMCM_RST;
        end
        if (restart) begin
            state_d = S_MMCM_RST;
            retry_d = 4'd0;
        end
        case (state_d)
            S_MMCM_RST:    cnt_ld = LD_RST_HOLD;
            S_WAIT_LOCK:   cnt_ld = LD_LOCK_TO;
            S_LOCK_STABLE: cnt_ld = LD_STABLE;
            S_IDLY_RST:    cnt_ld = LD_IDLY_RST;
            S_WAIT_RDY:    cnt_ld = LD_RDY_TO;
            default:       cnt_ld = '0;
        endcase
        load  = restart || (state_d != state_q);
        cnt_d = load ? cnt_ld : (cnt_zero ? '0 : cnt_q - 1'b1);
    end

    always_ff @(posedge epb_clk or negedge epb_rst_n) begin
        if (!epb_rst_n) begin
            state_q      <= S_MMCM_RST;
            cnt_q        <= LD_RST_HOLD;
            retry_q      <= 4'd0;
            mmcm_reset_q <= 1'b1;
            idelay_rst_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            mmcm_reset_q <= (state_d == S_MMCM_RST) || (state_d == S_FAULT);
            idelay_rst_q <= (state_d == S_MMCM_RST) || (state_d == S_IDLY_RST) || (state_d == S_FAULT);
            sys_rst_q    <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign mmcm_reset  = mmcm_reset_q;
    assign idelay_rst  = idelay_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_roach_clk_rst_sequencer.sv
// Bench for roach_clk_rst_sequencer: phase-vector table, hand-written corner sequences, random lock/rdy traffic vs an elapsed-time model.
module tb_roach_clk_rst_sequencer;

    localparam int RH = 64, LSC = 128, LTO = 256, IRC = 16, RTO = 200, MAXR = 7;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       sys_lock = 1'b0, aux_lock = 1'b0, rdy = 1'b0, restart = 1'b0;
    logic       mmcm_reset, idelay_rst, sys_rst, ready, fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    roach_clk_rst_sequencer #(
        .RST_HOLD_CYCLES(RH), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTO),
        .IDELAY_RST_CYCLES(IRC), .RDY_TIMEOUT_CYCLES(RTO), .MAX_RETRIES(MAXR)
    ) dut (
        .epb_clk(clk), .epb_rst_n(rst_n), .sys_clk_lock_in(sys_lock), .aux_clk_lock_in(aux_lock),
        .idelay_rdy(rdy), .restart(restart), .mmcm_reset(mmcm_reset), .idelay_rst(idelay_rst),
        .sys_rst(sys_rst), .ready(ready), .fault(fault), .retry_count(retry_count), .state(state)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference: phase code + cycles spent in the phase (counting up) + delayed pin samples {sys,aux,rdy}.
    int         m_state, m_n, m_retry;
    logic [2:0] h1, h2;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_n = 1; m_retry = 0; h1 = 3'b000; h2 = 3'b000;
    endtask

    task automatic model_step();
        bit lk, rd, fl;
        int nxt;
`ifdef AUX_LOCK_EN
        lk = h2[2] & h2[1];
`else
        lk = h2[2];
`endif
        rd  = h2[0];
        nxt = m_state;
        fl  = 0;
        case (m_state)
            0: if (m_n >= RH) nxt = 1;
            1: if (lk) nxt = 2; else if (m_n >= LTO) fl = 1;
            2: if (!lk) nxt = 1; else if (m_n >= LSC) nxt = 3;
            3: if (m_n >= IRC) nxt = 4;
            4: if (!lk) fl = 1; else if (rd) nxt = 5; else if (m_n >= RTO) fl = 1;
            5: if (!lk) fl = 1;
            default: ;
        endcase
        if (fl) begin
            if (m_retry < 15) m_retry++;
            nxt = (m_retry == MAXR) ? 6 : 0;
        end
        if (restart) begin
            nxt = 0; m_retry = 0;
        end
        m_n     = (restart || nxt != m_state) ? 1 : m_n + 1;
        m_state = nxt;
        h2 = h1;
        h1 = {sys_lock, aux_lock, rdy};
    endtask

    function automatic logic [11:0] exp_vec();
        logic mm, id, sr, rd, ft;
        mm = (m_state == 0) || (m_state == 6);
        id = (m_state == 0) || (m_state == 3) || (m_state == 6);
        sr = (m_state != 5);
        rd = (m_state == 5);
        ft = (m_state == 6);
        return {3'(m_state), mm, id, sr, rd, ft, 4'(m_retry)};
    endfunction

    task automatic tick(input int n);
        logic [11:0] dv;
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            dv = {state, mmcm_reset, idelay_rst, sys_rst, ready, fault, retry_count};
            check("model", int'(dv), int'(exp_vec()));
        end
    endtask

    // Called 1 time unit after an edge; asserts reset mid-cycle and checks outputs before the next edge.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_rst_state"}, state, 0);
        check({tag, "_rst_resets"}, {mmcm_reset, idelay_rst, sys_rst}, 3'b111);
        check({tag, "_rst_flags"}, {ready, fault, retry_count}, 6'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_state(input int s, input int budget, input string what);
        int k = 0;
        while (int'(state) != s && k < budget) begin
            tick(1);
            k++;
        end
        if (int'(state) != s) check({what, "_timeout"}, state, s);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    typedef struct {
        bit lock; bit rdy; bit rst; int cycles;
        int e_state; bit e_ready; int e_retry; bit e_sys;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int k;
        bit seen_wl;
        int lock_hold, rdy_hold;

        // Cycle counts are edges after reset release.
        tbl[0] = '{0, 0, 0, 10,  0, 0, 0, 1};  // edge 10: holding MMCM reset
        tbl[1] = '{0, 0, 0, 60,  1, 0, 0, 1};  // edge 70: hold ended at 64, waiting for lock
        tbl[2] = '{1, 0, 0, 60,  2, 0, 0, 1};  // edge 130: lock accepted at 73, stabilising
        tbl[3] = '{1, 0, 0, 100, 4, 0, 0, 1};  // edge 230: IDLY_RST 201..217, waiting rdy
        tbl[4] = '{1, 1, 0, 10,  5, 1, 0, 0};  // edge 240: RUN from 233
        tbl[5] = '{0, 1, 0, 10,  0, 0, 1, 1};  // edge 250: lock loss at 243 -> retry
        tbl[6] = '{0, 1, 1, 1,   0, 0, 0, 1};  // restart clears retry_count

        aux_lock = 1'b1;
        do_reset("init");

        for (int i = 0; i < 7; i++) begin
            sys_lock = tbl[i].lock;
            rdy      = tbl[i].rdy;
            restart  = tbl[i].rst;
            tick(tbl[i].cycles);
            check($sformatf("vec%0d_state", i), state, tbl[i].e_state);
            check($sformatf("vec%0d_ready", i), ready, tbl[i].e_ready);
            check($sformatf("vec%0d_retry", i), retry_count, tbl[i].e_retry);
            check($sformatf("vec%0d_sys_rst", i), sys_rst, tbl[i].e_sys);
        end
        restart = 1'b0;

        // Nominal bring-up from reset with pulse widths.
        sys_lock = 1'b0; rdy = 1'b0;
        do_reset("nom");
        k = 0;
        while (mmcm_reset && k < 1000) begin tick(1); k++; end
        check("mmcm_width", k, RH);
        tick(99);
        sys_lock = 1'b1;
        k = 0;
        while (!idelay_rst && k < LSC + 50) begin tick(1); k++; end
        k = 0;
        while (idelay_rst && k < 100) begin tick(1); k++; end
        check("idelay_width", k, IRC);
        tick(19);
        rdy = 1'b1;
        k = 0;
        while (sys_rst && k < 50) begin tick(1); k++; end
        check("nom_rdy_latency", k, 3);
        check("nom_ready", {ready, sys_rst}, 2'b10);
        check("nom_retry", retry_count, 0);

        // Lock loss in RUN.
        sys_lock = 1'b0;
        k = 0;
        while (!sys_rst && k < 10) begin tick(1); k++; end
        check("runloss_within_4", int'(k <= 4), 1);
        check("runloss_retry", retry_count, 1);
        k = 0;
        while (mmcm_reset && k < 1000) begin tick(1); k++; end
        check("runloss_mmcm_width", k, RH);

        // One-cycle lock glitch during LOCK_STABLE restarts the stable count without a retry.
        rdy = 1'b0; sys_lock = 1'b1;
        pulse_restart();
        wait_state(2, 300, "glitch_reach_ls");
        tick(50);
        sys_lock = 1'b0;
        tick(1);
        sys_lock = 1'b1;
        k = 1; seen_wl = 0;
        while (!idelay_rst && k < 400) begin
            tick(1); k++;
            if (state == 3'd1) seen_wl = 1;
        end
        check("glitch_seen_wait_lock", seen_wl, 1);
        check("glitch_to_idly_rst", k, LSC + 4);
        check("glitch_retry", retry_count, 0);

        // rdy timeout.
        k = 0;
        while (idelay_rst && k < 100) begin tick(1); k++; end
        k = 0;
        while (!mmcm_reset && k < RTO + 20) begin tick(1); k++; end
        check("rdy_timeout_cycles", k, RTO);
        check("rdy_timeout_retry", retry_count, 1);

        // Lock never arrives: MAXR timeouts, then FAULT; restart recovers.
        sys_lock = 1'b0;
        pulse_restart();
        k = 0;
        while (!fault && k < 3000) begin tick(1); k++; end
        check("fault_cycles", k, MAXR * (RH + LTO));
        check("fault_retry", retry_count, MAXR);
        check("fault_state", state, 6);
        check("fault_resets", {mmcm_reset, idelay_rst, sys_rst, ready}, 4'b1110);
        tick(20);
        check("fault_sticky", {fault, state}, {1'b1, 3'd6});
        pulse_restart();
        check("restart_from_fault", {fault, state, retry_count, mmcm_reset}, {1'b0, 3'd0, 4'd0, 1'b1});

        // Async reset in the middle of WAIT_RDY.
        sys_lock = 1'b1; rdy = 1'b0;
        pulse_restart();
        wait_state(4, 400, "reach_wait_rdy");
        tick(10);
        do_reset("midrdy");

        // aux lock low: stalls in WAIT_LOCK only when aux monitoring is built in.
        aux_lock = 1'b0; sys_lock = 1'b1;
        tick(RH + 100);
`ifdef AUX_LOCK_EN
        check("aux_low_stall", state, 1);
`else
        check("aux_ignored", state, 2);
`endif
        aux_lock = 1'b1;

        // Random lock/rdy/aux/restart traffic, checked every cycle against the model.
        pulse_restart();
        lock_hold = 0; rdy_hold = 0;
        for (int i = 0; i < 20000; i++) begin
            if (lock_hold == 0) begin
                sys_lock  = ($urandom_range(0, 9) < 8);
                lock_hold = sys_lock ? $urandom_range(50, 700) : $urandom_range(1, 60);
            end
            lock_hold--;
            if (rdy_hold == 0) begin
                rdy      = $urandom_range(0, 1);
                rdy_hold = $urandom_range(1, 150);
            end
            rdy_hold--;
            aux_lock = ($urandom_range(0, 499) != 0);
            restart  = ($urandom_range(0, 2999) == 0) || (fault && $urandom_range(0, 199) == 0);
            tick(1);
        end
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
